// File: rtl/coax_tx_arbiter.sv
// coax_tx_arbiter: frame-level round-robin scheduler that shares one coax transmitter
// between the host command path (req0) and the poll engine (req1).
//
// state  | meaning
// IDLE   | no frame owned; arbitrate between valid requesters
// ISSUE  | offer ready to the granted requester, wait for its next word
// LOAD   | tx_load high for one cycle with the captured word
// SETTLE | tx_load low for one cycle so tx_full reflects the load
// ROOM   | wait for the transmitter holding register to empty
// DRAIN  | last word loaded; wait for tx_active to rise and fall
// GAP    | enforce GAP_CLOCKS quiet cycles of tx_active low

module coax_tx_arbiter #(
   parameter int GAP_CLOCKS    = 16,
   parameter int START_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [9:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [9:0] tx_data,
   output logic       tx_load,
   input  logic       tx_full,
   input  logic       tx_active,
   output logic       busy,
   output logic       grant,
   output logic       underrun,
   output logic       start_error
);

   localparam int GW = $clog2(GAP_CLOCKS + 1);
   localparam int TW = $clog2(START_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_SETTLE,
      S_ROOM,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            last_grant;
   logic            last_lat;
   logic            frame_loaded;
   logic            active_seen;
   logic [GW-1:0]   gap_cnt;
   logic [TW-1:0]   start_cnt;

   logic            gnt_valid;
   logic [9:0]      gnt_data;
   logic            gnt_last;
   logic            pick;
   logic            in_frame;
   logic            start_timeout;
   logic            timeout_fire;
   logic            stall_underrun;
   logic            accept;
   logic            gap_done;

   assign gnt_valid = grant ? req1_valid : req0_valid;
   assign gnt_data  = grant ? req1_data  : req0_data;
   assign gnt_last  = grant ? req1_last  : req0_last;

   // On a tie the requester that did not own the previous frame wins.
   assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

   assign in_frame       = (state != S_IDLE) && (state != S_GAP);
   assign start_timeout  = frame_loaded && !active_seen && !tx_active && (start_cnt == '0);
   assign timeout_fire   = in_frame && start_timeout;
   assign stall_underrun = active_seen && !tx_active;
   assign accept         = (state == S_ISSUE) && gnt_valid && !start_timeout;
   assign gap_done       = !tx_active && (gap_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin : state_reg
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req0_valid || req1_valid) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (accept)                            state_nxt = S_LOAD;
            else if (!gnt_valid && stall_underrun) state_nxt = S_GAP;
         end
         S_LOAD: begin
            state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            state_nxt = last_lat ? S_DRAIN : S_ROOM;
         end
         S_ROOM: begin
            if (!tx_full) state_nxt = S_ISSUE;
         end
         S_DRAIN: begin
            if (active_seen && !tx_active) state_nxt = S_GAP;
         end
         S_GAP: begin
            if (gap_done) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // A frame that never reaches the line is abandoned outright.
      if (timeout_fire) state_nxt = S_GAP;
   end

   always_comb begin : outputs
      busy       = (state != S_IDLE);
      tx_load    = (state == S_LOAD);
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
   end

   always_ff @(posedge clk or posedge reset) begin : datapath
      if (reset) begin
         tx_data      <= '0;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
         last_lat     <= 1'b0;
         frame_loaded <= 1'b0;
         active_seen  <= 1'b0;
         gap_cnt      <= GW'(GAP_CLOCKS - 1);
         start_cnt    <= TW'(START_TIMEOUT - 2);
         underrun     <= 1'b0;
         start_error  <= 1'b0;
      end else begin
         underrun    <= (state == S_ISSUE) && !gnt_valid && stall_underrun;
         start_error <= timeout_fire;

         if ((state == S_IDLE) && (state_nxt == S_ISSUE)) begin
            grant      <= pick;
            last_grant <= pick;
         end

         if (accept) begin
            tx_data  <= gnt_data;
            last_lat <= gnt_last;
         end

         if (state_nxt == S_IDLE) begin
            frame_loaded <= 1'b0;
            active_seen  <= 1'b0;
         end else begin
            if (state == S_LOAD)            frame_loaded <= 1'b1;
            if (frame_loaded && tx_active)  active_seen  <= 1'b1;
         end

         // Start timer is armed by the first load; terminal count lands START_TIMEOUT clocks later.
         if ((state == S_LOAD) && !frame_loaded) begin
            start_cnt <= TW'(START_TIMEOUT - 2);
         end else if (frame_loaded && !active_seen && (start_cnt != '0)) begin
            start_cnt <= start_cnt - TW'(1);
         end

         // GAP lasts GAP_CLOCKS consecutive cycles with tx_active low.
         if (state == S_GAP) begin
            if (tx_active)           gap_cnt <= GW'(GAP_CLOCKS - 1);
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);
         end else begin
            gap_cnt <= GW'(GAP_CLOCKS - 1);
         end
      end
   end

endmodule

// File: tb/tb_coax_tx_arbiter.sv
// Self-checking bench for coax_tx_arbiter: behavioural transmitter, directed scenarios
// and a randomized round-robin run checked against a frame-level reference model.

module tb_coax_tx_arbiter;

   localparam int GAP         = 16;
   localparam int TMO         = 64;
   localparam int ACT_TAIL    = 8;
   localparam int WORD_BUDGET = 4000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] req0_data = '0;
   logic       req0_valid = 1'b0;
   logic       req0_last = 1'b0;
   logic       req0_ready;
   logic [9:0] req1_data = '0;
   logic       req1_valid = 1'b0;
   logic       req1_last = 1'b0;
   logic       req1_ready;
   logic [9:0] tx_data;
   logic       tx_load;
   logic       tx_full = 1'b0;
   logic       tx_active = 1'b0;
   logic       busy;
   logic       grant;
   logic       underrun;
   logic       start_error;

   always #5 clk = ~clk;

   coax_tx_arbiter #(.GAP_CLOCKS(GAP), .START_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_data   (req0_data),
      .req0_valid  (req0_valid),
      .req0_last   (req0_last),
      .req0_ready  (req0_ready),
      .req1_data   (req1_data),
      .req1_valid  (req1_valid),
      .req1_last   (req1_last),
      .req1_ready  (req1_ready),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .tx_full     (tx_full),
      .tx_active   (tx_active),
      .busy        (busy),
      .grant       (grant),
      .underrun    (underrun),
      .start_error (start_error)
   );

   typedef struct {int cyc; logic [9:0] d; logic g;} ld_t;
   typedef struct {logic [9:0] d; logic g;} ex_t;

   ld_t  ld_q[$];
   ex_t  ex_q[$];
   int   r0_q[$];
   int   r1_q[$];
   int   af_q[$];
   logic [9:0] s0_d[$];
   logic [9:0] s1_d[$];
   logic       s0_l[$];
   logic       s1_l[$];
   int   f0_start[$];
   int   f0_len[$];
   int   f1_start[$];
   int   f1_len[$];

   int   cyc = 0;
   int   un_cnt = 0;
   int   un_cyc = 0;
   int   se_cnt = 0;
   int   se_cyc = 0;
   int   full_viol = 0;
   int   busy_fall_cyc = 0;
   int   full_hold = 80;
   bit   act_en = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   bit   m_pend = 1'b0;
   int   m_full_cnt = 0;
   int   m_act_cnt = 0;
   logic m_prev_load = 1'b0;
   logic m_prev_busy = 1'b0;
   logic m_full_before = 1'b0;

   // Transmitter model: holding register fills one clock after a load edge and empties
   // full_hold clocks later; the line stays active until ACT_TAIL idle clocks pass.
   initial begin : tx_model
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            tx_full     = 1'b0;
            tx_active   = 1'b0;
            m_pend      = 1'b0;
            m_full_cnt  = 0;
            m_act_cnt   = 0;
            m_prev_load = 1'b0;
            m_prev_busy = 1'b0;
         end else begin
            m_full_before = tx_full;
            if (m_pend) begin
               tx_full    = 1'b1;
               m_full_cnt = full_hold;
               m_pend     = 1'b0;
               m_act_cnt  = 0;
               if (act_en) tx_active = 1'b1;
            end else if (tx_full) begin
               m_full_cnt--;
               if (m_full_cnt <= 0) begin
                  tx_full   = 1'b0;
                  m_act_cnt = ACT_TAIL;
               end
            end else if (m_act_cnt > 0) begin
               m_act_cnt--;
               if (m_act_cnt == 0 && tx_active) begin
                  tx_active = 1'b0;
                  af_q.push_back(cyc);
               end
            end
            if (tx_load && !m_prev_load) begin
               ld_q.push_back('{cyc, tx_data, grant});
               if (m_full_before) full_viol++;
               m_pend = 1'b1;
            end
            if (req0_ready) r0_q.push_back(cyc);
            if (req1_ready) r1_q.push_back(cyc);
            if (underrun) begin un_cnt++; un_cyc = cyc; end
            if (start_error) begin se_cnt++; se_cyc = cyc; end
            if (m_prev_busy && !busy) busy_fall_cyc = cyc;
            m_prev_load = tx_load;
            m_prev_busy = busy;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: observed no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [9:0] d, input logic l);
      if (r == 0) begin
         req0_valid = v; req0_data = d; req0_last = l;
      end else begin
         req1_valid = v; req1_data = d; req1_last = l;
      end
   endtask

   task automatic clear_logs();
      ld_q.delete(); r0_q.delete(); r1_q.delete(); af_q.delete();
      un_cnt = 0; un_cyc = 0; se_cnt = 0; se_cyc = 0; full_viol = 0; busy_fall_cyc = 0;
   endtask

   task automatic reset_dut();
      set_req(0, 1'b0, '0, 1'b0);
      set_req(1, 1'b0, '0, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      clear_logs();
   endtask

   task automatic drive_word(input int r, input logic [9:0] d, input logic l, input string tag);
      int  n = 0;
      bit  got = 1'b0;
      set_req(r, 1'b1, d, l);
      while (n < WORD_BUDGET) begin
         @(negedge clk);
         if (((r == 0) ? req0_ready : req1_ready) === 1'b1) begin
            got = 1'b1;
            break;
         end
         n++;
      end
      check(tag, got, 1);
      @(posedge clk);
      #1 set_req(r, 1'b0, '0, 1'b0);
   endtask

   task automatic drive_stream(input int r);
      int n = (r == 0) ? s0_d.size() : s1_d.size();
      for (int i = 0; i < n; i++) begin
         if (r == 0) drive_word(0, s0_d[i], s0_l[i], "rr_word0");
         else        drive_word(1, s1_d[i], s1_l[i], "rr_word1");
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      bit ok = 1'b0;
      repeat (2) @(negedge clk);
      while (n < 3000) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      check({tag, "_idle"}, ok, 1);
   endtask

   task automatic build_frames(input int r, input int nf);
      for (int f = 0; f < nf; f++) begin
         int len = int'($urandom_range(1, 4));
         if (r == 0) begin f0_start.push_back(s0_d.size()); f0_len.push_back(len); end
         else        begin f1_start.push_back(s1_d.size()); f1_len.push_back(len); end
         for (int w = 0; w < len; w++) begin
            logic [9:0] d = 10'($urandom_range(0, 1023));
            if (r == 0) begin s0_d.push_back(d); s0_l.push_back(w == len - 1); end
            else        begin s1_d.push_back(d); s1_l.push_back(w == len - 1); end
         end
      end
   endtask

   initial begin : main
      int  nf0, nf1, i0, i1, n, got;
      logic lg, p;

      // Reset values
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_tx_load", tx_load, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_underrun", underrun, 0);
      check("rst_start_error", start_error, 0);
      reset = 1'b0;
      clear_logs();

      // Single three-word frame from req0 with a slow transmitter
      full_hold = 80;
      drive_word(0, 10'h155, 1'b0, "t1_w0");
      drive_word(0, 10'h2AA, 1'b0, "t1_w1");
      drive_word(0, 10'h001, 1'b1, "t1_w2");
      wait_idle("t1");
      check("t1_loads", ld_q.size(), 3);
      check("t1_ready0", r0_q.size(), 3);
      if (ld_q.size() >= 3) begin
         check("t1_d0", ld_q[0].d, 10'h155);
         check("t1_d1", ld_q[1].d, 10'h2AA);
         check("t1_d2", ld_q[2].d, 10'h001);
         check("t1_g2", ld_q[2].g, 0);
      end
      check("t1_full_viol", full_viol, 0);
      check("t1_underrun", un_cnt, 0);
      check("t1_af", af_q.size(), 1);
      if (af_q.size() >= 1) check("t1_busy_fall", busy_fall_cyc, af_q[0] + GAP + 1);

      // Randomized round-robin run, both requesters valid from reset
      reset_dut();
      full_hold = int'($urandom_range(1, 12));
      nf0 = int'($urandom_range(2, 4));
      nf1 = int'($urandom_range(2, 4));
      build_frames(0, nf0);
      build_frames(1, nf1);
      i0 = 0; i1 = 0; lg = 1'b1;
      while (i0 < nf0 || i1 < nf1) begin
         if (i0 < nf0 && i1 < nf1) p = ~lg;
         else                      p = (i1 < nf1);
         if (!p) begin
            for (int k = 0; k < f0_len[i0]; k++) ex_q.push_back('{s0_d[f0_start[i0] + k], 1'b0});
            i0++;
         end else begin
            for (int k = 0; k < f1_len[i1]; k++) ex_q.push_back('{s1_d[f1_start[i1] + k], 1'b1});
            i1++;
         end
         lg = p;
      end
      fork
         begin drive_stream(0); end
         begin drive_stream(1); end
      join
      wait_idle("rr");
      check("rr_count", ld_q.size(), ex_q.size());
      for (int i = 0; i < ex_q.size(); i++) begin
         if (i < ld_q.size()) begin
            check($sformatf("rr_d%0d", i), ld_q[i].d, ex_q[i].d);
            check($sformatf("rr_g%0d", i), ld_q[i].g, ex_q[i].g);
         end
      end
      check("rr_ready0", r0_q.size(), s0_d.size());
      check("rr_ready1", r1_q.size(), s1_d.size());
      check("rr_full_viol", full_viol, 0);
      check("rr_underrun", un_cnt, 0);
      check("rr_start_error", se_cnt, 0);

      // Mid-frame contention: req1 raises valid during a req0 frame
      clear_logs();
      full_hold = 6;
      fork
         begin
            drive_word(0, 10'h0A1, 1'b0, "t3_w0");
            drive_word(0, 10'h0A2, 1'b0, "t3_w1");
            drive_word(0, 10'h0A3, 1'b1, "t3_w2");
         end
         begin
            n = 0;
            while (r0_q.size() < 1 && n < WORD_BUDGET) begin @(negedge clk); n++; end
            drive_word(1, 10'h3B7, 1'b1, "t3_r1");
         end
      join
      wait_idle("t3");
      check("t3_loads", ld_q.size(), 4);
      if (ld_q.size() >= 4) begin
         check("t3_g3", ld_q[3].g, 1);
         check("t3_d3", ld_q[3].d, 10'h3B7);
      end
      if (af_q.size() >= 1 && r1_q.size() >= 1)
         check("t3_r1_after_gap", r1_q[0], af_q[0] + GAP + 2);
      else
         check("t3_events", af_q.size() + r1_q.size(), 2);

      // Underrun: one non-last word then the requester stalls
      clear_logs();
      full_hold = 10;
      drive_word(0, 10'h0F0, 1'b0, "t4_w0");
      wait_idle("t4");
      check("t4_underrun_cnt", un_cnt, 1);
      if (af_q.size() >= 1) begin
         check("t4_underrun_cyc", un_cyc, af_q[0] + 1);
         check("t4_busy_fall", busy_fall_cyc, af_q[0] + GAP + 1);
      end
      repeat (40) @(negedge clk);
      check("t4_no_more_loads", ld_q.size(), 1);

      // Start timeout: the line never goes active
      clear_logs();
      act_en = 1'b0;
      drive_word(0, 10'h3C3, 1'b1, "t5_w0");
      wait_idle("t5");
      act_en = 1'b1;
      check("t5_start_error_cnt", se_cnt, 1);
      if (ld_q.size() >= 1) check("t5_start_error_cyc", se_cyc, ld_q[0].cyc + TMO);
      check("t5_busy_fall", busy_fall_cyc, se_cyc + GAP);
      check("t5_underrun", un_cnt, 0);

      // Async reset while waiting in ROOM with tx_full high, during a req1 frame
      clear_logs();
      full_hold = 80;
      set_req(1, 1'b1, 10'h2A5, 1'b0);
      n = 0; got = 0;
      while (n < 200) begin
         @(negedge clk);
         if (req1_ready === 1'b1) begin got = 1; break; end
         n++;
      end
      check("t6_ready1", got, 1);
      @(posedge clk);
      #1 set_req(1, 1'b1, 10'h05A, 1'b1);
      n = 0; got = 0;
      while (n < 20) begin
         @(negedge clk);
         if (tx_full === 1'b1) begin got = 1; break; end
         n++;
      end
      check("t6_full", got, 1);
      repeat (3) @(negedge clk);
      #1;
      check("t6_pre_busy", busy, 1);
      check("t6_pre_grant", grant, 1);
      reset = 1'b1;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_tx_load", tx_load, 0);
      check("t6_rst_ready1", req1_ready, 0);
      check("t6_rst_grant", grant, 0);
      check("t6_rst_tx_data", tx_data, 0);
      set_req(1, 1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      clear_logs();
      fork
         begin drive_word(0, 10'h111, 1'b1, "t6_r0"); end
         begin drive_word(1, 10'h222, 1'b1, "t6_r1"); end
      join
      wait_idle("t6");
      check("t6_loads", ld_q.size(), 2);
      if (ld_q.size() >= 2) begin
         check("t6_g0", ld_q[0].g, 0);
         check("t6_d0", ld_q[0].d, 10'h111);
         check("t6_g1", ld_q[1].g, 1);
         check("t6_d1", ld_q[1].d, 10'h222);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
